// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: 8-way round-robin arbiter in front of a shared 3:8 decoder (grant, hold until done, one-cycle gap, next winner)
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req[7:0] in   level request per agent
//   done     in   owner finished, looked at only while granted
//   gnt_en   out  decoder enable, high while a grant is active
//   gnt_idx  out  current/last owner, decoder select
//   gnt[7:0] out  one-hot grant, gnt_en ? 1 << gnt_idx : 0
//   busy     out  high in GRANT and GAP
//   timeout  out  one-cycle pulse in GAP after a forced release
//   Optional macro DEC_ARB_TIMEOUT_EN: forces release after MAX_HOLD grant cycles.
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_en,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("dec_rr_arbiter: MAX_HOLD must be 2..255");
    end
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_en_q, gnt_en_d;
    logic [7:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [2:0] win;
    logic       any_req, owner_req, forced, release_c;
    assign any_req   = |req;
    assign owner_req = req[gnt_idx_q];
    // Descending scan so the requester closest to ptr overwrites the others.
    always_comb begin
        win = ptr_q;
        for (int k = 7; k >= 0; k--)
            if (req[ptr_q + 3'(k)]) win = ptr_q + 3'(k);
    end
`ifdef DEC_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    // Held at zero outside GRANT, so every grant starts counting from 0.
    always_comb hold_d = (state_q == GRANT) ? hold_q + 8'd1 : 8'd0;
    always_ff @(posedge clk)
        hold_q <= rst ? 8'd0 : hold_d;
    assign forced = (state_q == GRANT) && (hold_q == 8'(MAX_HOLD - 1));
`else
    assign forced = 1'b0;
`endif
    assign release_c = done | ~owner_req | forced;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            gnt_idx_q <= 3'd0;
            gnt_en_q  <= 1'b0;
            gnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_en_q  <= gnt_en_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req ? GRANT : IDLE;
            GRANT:   state_d = release_c ? GAP : GRANT;
            GAP:     state_d = any_req ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        gnt_en_d  = state_d == GRANT;
        busy_d    = state_d != IDLE;
        gnt_idx_d = (state_q != GRANT && any_req) ? win : gnt_idx_q;
        ptr_d     = (state_q == GRANT && release_c) ? gnt_idx_q + 3'd1 : ptr_q;
        timeout_d = forced && !done && owner_req;
        gnt_d     = gnt_en_d ? 8'b1 << gnt_idx_d : 8'd0;
    end
    assign gnt_en  = gnt_en_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb_dec_rr_arbiter: directed self-checking bench with a behavioural round-robin model
module tb_dec_rr_arbiter;
    localparam int MH = 4;
`ifdef DEC_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       gnt_en, busy, timeout;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    dec_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_en(gnt_en), .gnt_idx(gnt_idx), .gnt(gnt), .busy(busy), .timeout(timeout)
    );
    always #5 clk = ~clk;
    // phase: 0 idle, 1 owner holds the resource, 2 dead cycle between owners
    typedef struct packed {
        int phase;
        int ptr;
        int owner;
        int held;
        bit en;
        bit busy;
        bit to;
    } ms_t;
    ms_t m = '0;
    bit  started = 1'b0;
    int  checks = 0;
    int  errors = 0;
    int  l_seq = 0;
    int  l_done = 0;
    string      l_name = "";
    logic [13:0] l_exp = '0;
    function automatic int pick(int p, logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return p;
    endfunction
    function automatic ms_t step(ms_t s, logic [7:0] r, logic d, logic rs);
        ms_t n = s;
        bit frc;
        n.to = 1'b0;
        if (rs) return '0;
        if (s.phase == 0 || s.phase == 2) begin
            if (r != 8'h00) begin
                n.phase = 1;
                n.owner = pick(s.ptr, r);
                n.en = 1'b1;
                n.busy = 1'b1;
                n.held = 0;
            end else begin
                n.phase = 0;
                n.busy = 1'b0;
            end
        end else begin
            frc = TO_EN && (s.held + 1 == MH);
            if (d || !r[s.owner] || frc) begin
                n.phase = 2;
                n.en = 1'b0;
                n.ptr = (s.owner + 1) % 8;
                n.to = frc && !d && r[s.owner];
            end else
                n.held = s.held + 1;
        end
        return n;
    endfunction
    initial forever begin
        @(posedge clk);
        m = step(m, req, done, rst);
        started = 1'b1;
    end
    initial forever begin
        logic [7:0] exp_g;
        @(negedge clk);
        if (started) begin
            exp_g = m.en ? 8'h01 << m.owner : 8'h00;
            checks++;
            if ({gnt_en, gnt_idx, gnt, busy, timeout} !== {m.en, 3'(m.owner), exp_g, m.busy, m.to}) begin
                errors++;
                $display("FAIL model t=%0t got en=%b idx=%0d gnt=%b busy=%b to=%b want en=%b idx=%0d gnt=%b busy=%b to=%b",
                         $time, gnt_en, gnt_idx, gnt, busy, timeout, m.en, m.owner, exp_g, m.busy, m.to);
            end
        end
        if (l_seq != l_done) begin
            l_done = l_seq;
            checks++;
            if ({gnt_en, gnt_idx, gnt, busy, timeout} !== l_exp) begin
                errors++;
                $display("FAIL %s t=%0t got {en,idx,gnt,busy,to}=%b want %b",
                         l_name, $time, {gnt_en, gnt_idx, gnt, busy, timeout}, l_exp);
            end
        end
    end
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic lit(string nm, bit en, logic [2:0] idx, logic [7:0] g, bit b, bit to);
        l_name = nm;
        l_exp = {en, idx, g, b, to};
        l_seq++;
    endtask
    initial begin
        logic [7:0] one;
        int idx;
        one = 8'h01;
        cyc(2);
        rst = 1'b0;
        req = 8'hFF;
        cyc(2);
        lit("pre_rst", 1, 3'd0, 8'h01, 1, 0);
        rst = 1'b1;
        cyc(1);
        lit("rst_mid", 0, 3'd0, 8'h00, 0, 0);
        rst = 1'b0;
        req = 8'h00;
        cyc(1);
        req = 8'h04;
        cyc(1);
        lit("single_gnt", 1, 3'd2, 8'h04, 1, 0);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        lit("single_gap", 0, 3'd2, 8'h00, 1, 0);
        cyc(1);
        lit("single_regnt", 1, 3'd2, 8'h04, 1, 0);
        req = 8'h00;
        cyc(1);
        lit("drop_gap", 0, 3'd2, 8'h00, 1, 0);
        cyc(1);
        lit("back_idle", 0, 3'd2, 8'h00, 0, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 8'hFF;
        cyc(1);
        for (int k = 0; k < 9; k++) begin
            idx = k % 8;
            lit("rr_c1", 1, 3'(idx), one << idx, 1, 0);
            cyc(1);
            lit("rr_c2", 1, 3'(idx), one << idx, 1, 0);
            done = 1'b1;
            cyc(1);
            done = 1'b0;
            lit("rr_gap", 0, 3'(idx), 8'h00, 1, 0);
            cyc(1);
        end
        lit("rr_next", 1, 3'd1, 8'h02, 1, 0);
        req = 8'h40;
        cyc(1);
        cyc(1);
        lit("grant6", 1, 3'd6, 8'h40, 1, 0);
        req = 8'h81;
        cyc(1);
        lit("wrap_gap", 0, 3'd6, 8'h00, 1, 0);
        cyc(1);
        lit("wrap7", 1, 3'd7, 8'h80, 1, 0);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        lit("wrap0", 1, 3'd0, 8'h01, 1, 0);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        cyc(1);
        lit("wrap7b", 1, 3'd7, 8'h80, 1, 0);
        req = 8'h20;
        cyc(2);
        lit("wd_5", 1, 3'd5, 8'h20, 1, 0);
        req = 8'h08;
        cyc(1);
        lit("wd_gap", 0, 3'd5, 8'h00, 1, 0);
        cyc(1);
        lit("wd_3", 1, 3'd3, 8'h08, 1, 0);
        req = 8'h0F;
        cyc(2);
        lit("nonowner", 1, 3'd3, 8'h08, 1, 0);
        req = 8'h02;
        cyc(2);
        lit("hold_1", 1, 3'd1, 8'h02, 1, 0);
`ifdef DEC_ARB_TIMEOUT_EN
        cyc(3);
        lit("to_last", 1, 3'd1, 8'h02, 1, 0);
        cyc(1);
        lit("to_gap", 0, 3'd1, 8'h00, 1, 1);
        cyc(1);
        lit("to_regnt", 1, 3'd1, 8'h02, 1, 0);
`else
        cyc(120);
        lit("no_to", 1, 3'd1, 8'h02, 1, 0);
`endif
        req = 8'h00;
        cyc(3);
        lit("end_idle", 0, 3'd1, 8'h00, 0, 0);
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
